// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// opcodes, FSM states, ALU and mux select codes, control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/controle_multiciclo_saidas.sv
// Combinational decoder from FSM state to datapath control word.
// Only FETCH's ir/pc writes look at the live memory handshake.
module controle_multiciclo_saidas
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_OUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: next-state logic, sticky illegal
// flag, fetch counter; outputs forced low while reset is high.
module controle_multiciclo
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic             illegal_q;
    logic             illegal_d;
    logic [CNT_W-1:0] instr_count_q;
    logic [CNT_W-1:0] instr_count_d;
    ctrl_t            ctrl;
    ctrl_t            ctrl_g;

    controle_multiciclo_saidas u_saidas (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(opcode))
                    state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)
                    state_d = S_EXEC;
                else if (opcode == OP_BEQ)
                    state_d = S_BRANCH;
                else if (opcode == OP_J)
                    state_d = S_JUMP;
                else
                    state_d = S_HALT;
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        illegal_d = illegal_q;
        if (state_d == S_HALT)
            illegal_d = 1'b1;
        instr_count_d = instr_count_q;
        if (state_q == S_FETCH && mem_ready)
            instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Gate the whole control word so no request escapes during reset.
    always_comb begin
        ctrl_g = reset ? '0 : ctrl;
    end

    assign pc_en       = ctrl_g.pc_write | (ctrl_g.pc_write_cond & zero);
    assign pc_source   = ctrl_g.pc_source;
    assign i_or_d      = ctrl_g.i_or_d;
    assign mem_read    = ctrl_g.mem_read;
    assign mem_write   = ctrl_g.mem_write;
    assign ir_write    = ctrl_g.ir_write;
    assign reg_dst     = ctrl_g.reg_dst;
    assign mem_to_reg  = ctrl_g.mem_to_reg;
    assign reg_write   = ctrl_g.reg_write;
    assign alu_src_a   = ctrl_g.alu_src_a;
    assign alu_src_b   = ctrl_g.alu_src_b;
    assign alu_op      = ctrl_g.alu_op;
    assign illegal     = reset ? 1'b0 : illegal_q;
    assign state       = reset ? 4'd0 : state_q;
    assign instr_count = reset ? '0 : instr_count_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: each cycle's inputs are
// driven after the falling edge and outputs checked 1ns later.
module tb_controle_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    always #5 clk = ~clk;

    controle_multiciclo #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .pc_source   (pc_source),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [5:0] op, input logic z, input logic r);
        @(negedge clk);
        opcode    = op;
        zero      = z;
        mem_ready = r;
        #1;
    endtask

    function automatic logic [4:0] enables();
        return {pc_en, mem_read, mem_write, ir_write, reg_write};
    endfunction

    initial begin
        reset = 1'b1; opcode = LW; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_en", {27'd0, enables()}, 32'd0);
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_ill", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        // lw: 0,1,2,3,4
        chk("lw_f_state", {28'd0, state}, 32'd0);
        chk("lw_f_en", {27'd0, enables()}, 32'b11010);
        chk("lw_f_srcb", {30'd0, alu_src_b}, 32'd1);
        cyc(LW, 0, 1);
        chk("lw_d_state", {28'd0, state}, 32'd1);
        chk("lw_d_srcb", {30'd0, alu_src_b}, 32'd3);
        chk("lw_d_rw", {31'd0, reg_write}, 32'd0);
        cyc(LW, 0, 1);
        chk("lw_a_state", {28'd0, state}, 32'd2);
        chk("lw_a_srca", {31'd0, alu_src_a}, 32'd1);
        chk("lw_a_srcb", {30'd0, alu_src_b}, 32'd2);
        cyc(LW, 0, 1);
        chk("lw_r_state", {28'd0, state}, 32'd3);
        chk("lw_r_rd_iod", {30'd0, mem_read, i_or_d}, 32'b11);
        chk("lw_r_rw", {31'd0, reg_write}, 32'd0);
        cyc(LW, 0, 1);
        chk("lw_wb_state", {28'd0, state}, 32'd4);
        chk("lw_wb_rw_m2r", {30'd0, reg_write, mem_to_reg}, 32'b11);
        chk("lw_wb_dst", {31'd0, reg_dst}, 32'd0);
        cyc(RT, 0, 0);
        chk("lw_end_state", {28'd0, state}, 32'd0);
        chk("lw_cnt", instr_count, 32'd1);
        // R-type, two wait cycles in FETCH
        chk("rt_w1_en", {27'd0, enables()}, 32'b01000);
        cyc(RT, 0, 0);
        chk("rt_w2_state", {28'd0, state}, 32'd0);
        chk("rt_w2_en", {27'd0, enables()}, 32'b01000);
        cyc(RT, 0, 1);
        chk("rt_f_en", {27'd0, enables()}, 32'b11010);
        cyc(RT, 0, 1);
        chk("rt_d_state", {28'd0, state}, 32'd1);
        chk("rt_d_irw", {30'd0, ir_write, pc_en}, 32'd0);
        cyc(RT, 0, 1);
        chk("rt_ex_state", {28'd0, state}, 32'd6);
        chk("rt_ex_aluop", {30'd0, alu_op}, 32'd2);
        chk("rt_ex_srcs", {29'd0, alu_src_a, alu_src_b}, 32'b100);
        cyc(RT, 0, 1);
        chk("rt_wb_state", {28'd0, state}, 32'd7);
        chk("rt_wb_dst_rw", {29'd0, reg_dst, reg_write, mem_to_reg}, 32'b110);
        // beq taken
        cyc(BEQ, 1, 1);
        chk("beq1_f_state", {28'd0, state}, 32'd0);
        chk("rt_cnt", instr_count, 32'd2);
        cyc(BEQ, 1, 1);
        chk("beq1_d_state", {28'd0, state}, 32'd1);
        cyc(BEQ, 1, 1);
        chk("beq1_b_state", {28'd0, state}, 32'd8);
        chk("beq1_pcen", {31'd0, pc_en}, 32'd1);
        chk("beq1_pcsrc", {30'd0, pc_source}, 32'd1);
        chk("beq1_aluop", {30'd0, alu_op}, 32'd1);
        // beq not taken
        cyc(BEQ, 0, 1);
        chk("beq0_f_state", {28'd0, state}, 32'd0);
        cyc(BEQ, 0, 1);
        chk("beq0_d_state", {28'd0, state}, 32'd1);
        cyc(BEQ, 0, 1);
        chk("beq0_b_state", {28'd0, state}, 32'd8);
        chk("beq0_pcen", {31'd0, pc_en}, 32'd0);
        // sw with three memory wait cycles
        cyc(SW, 0, 1);
        chk("sw_f_state", {28'd0, state}, 32'd0);
        chk("beq_cnt", instr_count, 32'd4);
        cyc(SW, 0, 1);
        chk("sw_d_state", {28'd0, state}, 32'd1);
        cyc(SW, 0, 1);
        chk("sw_a_state", {28'd0, state}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            cyc(SW, 0, (i == 3));
            chk("sw_w_state", {28'd0, state}, 32'd5);
            chk("sw_w_req", {29'd0, mem_write, i_or_d, mem_read}, 32'b110);
            chk("sw_w_rw", {31'd0, reg_write}, 32'd0);
        end
        // jump
        cyc(JMP, 0, 1);
        chk("j_f_state", {28'd0, state}, 32'd0);
        chk("sw_cnt", instr_count, 32'd5);
        cyc(JMP, 0, 1);
        cyc(JMP, 0, 1);
        chk("j_state", {28'd0, state}, 32'd9);
        chk("j_pcen_src", {29'd0, pc_en, pc_source}, 32'b110);
        // illegal opcode
        cyc(BAD, 0, 1);
        chk("bad_f_state", {28'd0, state}, 32'd0);
        cyc(BAD, 0, 1);
        chk("bad_d_state", {28'd0, state}, 32'd1);
        chk("bad_d_ill", {31'd0, illegal}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(LW, 1, 1);
            chk("halt_state", {28'd0, state}, 32'd10);
            chk("halt_ill", {31'd0, illegal}, 32'd1);
            chk("halt_en", {27'd0, enables()}, 32'd0);
        end
        chk("halt_cnt", instr_count, 32'd7);
        reset = 1'b1;
        #1;
        chk("halt_rst_ill", {31'd0, illegal}, 32'd0);
        chk("halt_rst_state", {28'd0, state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ill", {31'd0, illegal}, 32'd0);
        chk("post_rst_rd", {31'd0, mem_read}, 32'd1);
        // reset during MEMRD wait
        cyc(LW, 0, 1);
        cyc(LW, 0, 1);
        cyc(LW, 0, 0);
        chk("mr_state", {28'd0, state}, 32'd3);
        chk("mr_req", {30'd0, mem_read, i_or_d}, 32'b11);
        chk("mr_cnt", instr_count, 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_rst_en", {27'd0, enables()}, 32'd0);
        chk("mr_rst_iod", {31'd0, i_or_d}, 32'd0);
        chk("mr_rst_state", {28'd0, state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_post_state", {28'd0, state}, 32'd0);
        chk("mr_post_cnt", instr_count, 32'd0);
        chk("mr_post_rd", {30'd0, mem_read, i_or_d}, 32'b10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
